// File: rtl/axi_ad9371_tx_dma_unpack.sv
// Unpacks a 128-bit DMA stream of packed enabled-channel words onto the four
// AD9371 TX channel inputs and flags underflow when a request goes unserved.
module axi_ad9371_tx_dma_unpack #(
  parameter int unsigned UNF_CNT_WIDTH = 16
) (
  input  logic                     dac_clk,
  input  logic                     up_rstn,
  input  logic                     dac_rst,
  input  logic [3:0]               dac_enable,
  input  logic                     dac_valid,
  input  logic                     dma_valid,
  input  logic [127:0]             dma_data,
  output logic                     dma_ready,
  output logic [31:0]              dac_data_i0,
  output logic [31:0]              dac_data_q0,
  output logic [31:0]              dac_data_i1,
  output logic [31:0]              dac_data_q1,
  output logic                     dac_dunf,
  output logic                     cfg_err,
  output logic [UNF_CNT_WIDTH-1:0] unf_count
);

  logic [127:0] buf_data;
  logic         buf_valid;
  logic [1:0]   ptr;
  logic [3:0]   en_shadow;
  logic [31:0]  dac_data [4];

  logic [2:0]   n_en;
  logic [2:0]   ptr_sum;
  logic         en_chg;
  logic         need;
  logic         avail;
  logic [127:0] src;
  logic [31:0]  slice [4];

  always_comb begin
    n_en = 3'd0;
    for (int c = 0; c < 4; c++) begin
      n_en = n_en + {2'b00, dac_enable[c]};
    end
  end

  assign cfg_err   = (n_en == 3'd0) || (n_en == 3'd3);
  assign en_chg    = (dac_enable != en_shadow);
  // An enable change costs one request slot so the flush and shadow update settle first.
  assign need      = dac_valid && !cfg_err && !dac_rst && !en_chg;
  assign src       = buf_valid ? buf_data : dma_data;
  assign avail     = buf_valid || dma_valid;
  assign dma_ready = need && !buf_valid;
  assign ptr_sum   = {1'b0, ptr} + n_en;

  // Word ptr+k lands on the k-th enabled channel in ascending channel order.
  always_comb begin
    logic [1:0] k;
    logic [1:0] widx;
    k    = 2'd0;
    widx = 2'd0;
    for (int c = 0; c < 4; c++) begin
      slice[c] = 32'd0;
      if (dac_enable[c]) begin
        widx     = ptr + k;
        slice[c] = src[{widx, 5'b00000} +: 32];
        k        = k + 2'd1;
      end
    end
  end

  always_ff @(posedge dac_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      buf_data  <= 128'd0;
      buf_valid <= 1'b0;
      ptr       <= 2'd0;
      en_shadow <= 4'd0;
      dac_dunf  <= 1'b0;
      unf_count <= '0;
      for (int c = 0; c < 4; c++) begin
        dac_data[c] <= 32'd0;
      end
    end else begin
      en_shadow <= dac_enable;
      dac_dunf  <= need && !avail;

      if (dac_rst || cfg_err) begin
        for (int c = 0; c < 4; c++) begin
          dac_data[c] <= 32'd0;
        end
      end else if (need) begin
        for (int c = 0; c < 4; c++) begin
          dac_data[c] <= avail ? slice[c] : 32'd0;
        end
      end

      if (dac_rst || en_chg) begin
        buf_valid <= 1'b0;
        ptr       <= 2'd0;
      end else if (need && avail) begin
        if (ptr_sum == 3'd4) begin
          buf_valid <= 1'b0;
          ptr       <= 2'd0;
        end else begin
          buf_data  <= src;
          buf_valid <= 1'b1;
          ptr       <= ptr_sum[1:0];
        end
      end

      if (need && !avail && !(&unf_count)) begin
        unf_count <= unf_count + 1'b1;
      end
    end
  end

  assign dac_data_i0 = dac_data[0];
  assign dac_data_q0 = dac_data[1];
  assign dac_data_i1 = dac_data[2];
  assign dac_data_q1 = dac_data[3];

endmodule

// File: tb/tb_axi_ad9371_tx_dma_unpack.sv
// Directed bench for axi_ad9371_tx_dma_unpack: steps through the channel modes,
// underflow, enable changes, dac_rst, bad configs and async reset.
module tb_axi_ad9371_tx_dma_unpack;

  logic         dac_clk;
  logic         up_rstn;
  logic         dac_rst;
  logic [3:0]   dac_enable;
  logic         dac_valid;
  logic         dma_valid;
  logic [127:0] dma_data;
  logic         dma_ready;
  logic [31:0]  dac_data_i0, dac_data_q0, dac_data_i1, dac_data_q1;
  logic         dac_dunf;
  logic         cfg_err;
  logic [15:0]  unf_count;

  int vectors;
  int miscompares;

  localparam logic [31:0] WA = 32'h1111_000A, WB = 32'h2222_000B, WC = 32'h3333_000C;
  localparam logic [31:0] WD = 32'h4444_000D, WE = 32'h5555_000E, WF = 32'h6666_000F;
  localparam logic [31:0] WG = 32'h7777_0010, WH = 32'h8888_0011;
  localparam logic [127:0] BEAT1 = {WD, WC, WB, WA};
  localparam logic [127:0] BEAT2 = {WH, WG, WF, WE};

  axi_ad9371_tx_dma_unpack #(.UNF_CNT_WIDTH(16)) dut (
    .dac_clk    (dac_clk),
    .up_rstn    (up_rstn),
    .dac_rst    (dac_rst),
    .dac_enable (dac_enable),
    .dac_valid  (dac_valid),
    .dma_valid  (dma_valid),
    .dma_data   (dma_data),
    .dma_ready  (dma_ready),
    .dac_data_i0(dac_data_i0),
    .dac_data_q0(dac_data_q0),
    .dac_data_i1(dac_data_i1),
    .dac_data_q1(dac_data_q1),
    .dac_dunf   (dac_dunf),
    .cfg_err    (cfg_err),
    .unf_count  (unf_count)
  );

  initial dac_clk = 1'b0;
  always #5 dac_clk = ~dac_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i0, input logic [31:0] q0,
                         input logic [31:0] i1, input logic [31:0] q1, input logic dunf);
    chk({tag, ".i0"}, dac_data_i0, i0);
    chk({tag, ".q0"}, dac_data_q0, q0);
    chk({tag, ".i1"}, dac_data_i1, i1);
    chk({tag, ".q1"}, dac_data_q1, q1);
    chk({tag, ".dunf"}, {31'd0, dac_dunf}, {31'd0, dunf});
  endtask

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    up_rstn     = 1'b0;
    dac_rst     = 1'b0;
    dac_enable  = 4'h0;
    dac_valid   = 1'b0;
    dma_valid   = 1'b0;
    dma_data    = 128'd0;
    #12;
    chk_out("reset", 0, 0, 0, 0, 1'b0);
    chk("reset.unf", {16'd0, unf_count}, 32'd0);
    chk("reset.cfg_err", {31'd0, cfg_err}, 32'd1);
    up_rstn = 1'b1;
    tick();

    // N=4: one beat per request
    dac_enable = 4'hF;
    tick();
    dac_valid = 1'b1;
    dma_valid = 1'b1;
    dma_data  = {32'h4, 32'h3, 32'h2, 32'h1};
    #1 chk("n4.ready0", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("n4.b0", 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    chk("n4.ready1", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("n4.b1", 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);

    // Underflow for three requests, then resume
    dma_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("unf", 0, 0, 0, 0, 1'b1);
    end
    chk("unf.count", {16'd0, unf_count}, 32'd3);
    dma_valid = 1'b1;
    dma_data  = {32'h8, 32'h7, 32'h6, 32'h5};
    tick();
    chk_out("unf.resume", 32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
    dac_valid = 1'b0;
    tick();
    chk_out("idle.hold", 32'h5, 32'h6, 32'h7, 32'h8, 1'b0);

    // N=2 on i0/i1; enable change cycle suppresses the request
    dac_enable = 4'b0101;
    dac_valid  = 1'b1;
    dma_data   = BEAT1;
    #1 chk("n2.chg.ready", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("n2.chg.hold", 32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
    chk("n2.ready.a", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("n2.ab", WA, 0, WB, 0, 1'b0);
    dma_data = BEAT2;
    #1 chk("n2.ready.b", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("n2.cd", WC, 0, WD, 0, 1'b0);
    chk("n2.ready.c", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("n2.ef", WE, 0, WF, 0, 1'b0);
    chk("n2.ready.d", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("n2.gh", WG, 0, WH, 0, 1'b0);

    // N=1 on q1: four requests per beat
    dac_enable = 4'b1000;
    dma_data   = BEAT1;
    tick();
    chk("n1.ready0", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("n1.a", 0, 0, 0, WA, 1'b0);
    chk("n1.ready1", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("n1.b", 0, 0, 0, WB, 1'b0);
    tick();
    chk_out("n1.c", 0, 0, 0, WC, 1'b0);
    tick();
    chk_out("n1.d", 0, 0, 0, WD, 1'b0);
    chk("n1.ready4", {31'd0, dma_ready}, 32'd1);

    // Mid-beat switch from N=1 to N=2 drops the partial beat
    tick();
    tick();
    chk_out("mid.b", 0, 0, 0, WB, 1'b0);
    dac_enable = 4'b0101;
    dma_data   = BEAT2;
    tick();
    chk_out("mid.chg.hold", 0, 0, 0, WB, 1'b0);
    chk("mid.ready", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("mid.ef", WE, 0, WF, 0, 1'b0);

    // dac_rst flushes buffer and outputs but keeps the underflow count
    dac_rst = 1'b1;
    #1 chk("rst.ready", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("rst", 0, 0, 0, 0, 1'b0);
    chk("rst.unf", {16'd0, unf_count}, 32'd3);
    dac_rst  = 1'b0;
    dma_data = BEAT1;
    #1 chk("rst.ready.after", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("rst.ab", WA, 0, WB, 0, 1'b0);

    // Three enabled channels is an unsupported config
    dac_enable = 4'b0111;
    #1 chk("cfg.err", {31'd0, cfg_err}, 32'd1);
    chk("cfg.ready", {31'd0, dma_ready}, 32'd0);
    tick();
    chk_out("cfg.out0", 0, 0, 0, 0, 1'b0);
    tick();
    chk_out("cfg.out1", 0, 0, 0, 0, 1'b0);
    chk("cfg.unf", {16'd0, unf_count}, 32'd3);

    // Async reset mid-beat, next beat starts at word 0
    dac_enable = 4'b0001;
    tick();
    tick();
    chk_out("ar.a", WA, 0, 0, 0, 1'b0);
    #2 up_rstn = 1'b0;
    #1;
    chk_out("ar.rst", 0, 0, 0, 0, 1'b0);
    chk("ar.unf", {16'd0, unf_count}, 32'd0);
    up_rstn  = 1'b1;
    dma_data = BEAT2;
    tick();
    chk_out("ar.chg.hold", 0, 0, 0, 0, 1'b0);
    chk("ar.ready", {31'd0, dma_ready}, 32'd1);
    tick();
    chk_out("ar.e", WE, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
